// File: rtl/crossbar_pkg.sv
// Shared types and helpers for the sparse-datapath lane crossbar.
// Lane slice: bits of lane idx in a flat vector of w-bit lanes.
`ifndef XB_LANE
`define XB_LANE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package crossbar_pkg;
  typedef enum logic {IDLE, RUN} state_t;

  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/crossbar_route_unit_if.sv
// Config and stream handshakes between the operand fetch, the crossbar and the PE array.
interface crossbar_route_unit_if #(
  parameter int DW_DATA = 8,
  parameter int N_LANE  = 4,
  parameter int SEL_W   = crossbar_pkg::sel_w(N_LANE)
);
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [N_LANE*SEL_W-1:0]   cfg_sel;
  logic [N_LANE-1:0]         cfg_mask;
  logic                      cfg_bcast;
  logic                      in_valid;
  logic                      in_ready;
  logic [N_LANE*DW_DATA-1:0] in_data;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [N_LANE*DW_DATA-1:0] out_data;
  logic                      out_last;

  modport slave (
    input  cfg_valid, cfg_sel, cfg_mask, cfg_bcast, in_valid, in_data, in_last, out_ready,
    output cfg_ready, in_ready, out_valid, out_data, out_last
  );
  modport master (
    output cfg_valid, cfg_sel, cfg_mask, cfg_bcast, in_valid, in_data, in_last, out_ready,
    input  cfg_ready, in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/crossbar_skid_buf.sv
// Two-entry valid/ready register stage; head entry drives the output directly.
module crossbar_skid_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [1:0][W-1:0] mem;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        occ;
  logic              push, pop;

  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/crossbar_route_unit.sv
// N-lane registered crossbar: per-packet route config, routing done at input accept.
module crossbar_route_unit
  import crossbar_pkg::*;
#(
  parameter int DW_DATA = 8,
  parameter int N_LANE  = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  crossbar_route_unit_if.slave bus,
  output logic [CNT_W-1:0]     beat_cnt,
  output logic                 pkt_done
);
  localparam int SEL_W  = sel_w(N_LANE);
  localparam int N_EXT  = 1 << SEL_W;
  localparam int DW_BUS = N_LANE * DW_DATA;

  state_t                          state, state_nx;
  logic [N_LANE-1:0][SEL_W-1:0]    sel_q;
  logic [N_LANE-1:0]               mask_q;
  logic                            bcast_q;
  logic [N_EXT-1:0][DW_DATA-1:0]   lane_ext;
  logic [N_LANE-1:0][DW_DATA-1:0]  routed;
  logic                            sk_ready, in_fire, cfg_fire;
  logic [DW_BUS:0]                 sk_out;

  assign bus.cfg_ready = (state == IDLE) && !reset;
  assign bus.in_ready  = (state == RUN) && sk_ready;
  assign cfg_fire      = bus.cfg_valid && bus.cfg_ready;
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign pkt_done      = in_fire && bus.in_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cfg_fire) state_nx = RUN;
      RUN:     if (pkt_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q   <= '0;
      mask_q  <= '0;
      bcast_q <= 1'b0;
    end else if (cfg_fire) begin
      sel_q   <= bus.cfg_sel;
      mask_q  <= bus.cfg_mask;
      bcast_q <= bus.cfg_bcast;
    end
  end

  // Pad the source table to the full select range so out-of-range selects read zero.
  for (genvar k = 0; k < N_EXT; k++) begin : g_ext
    if (k < N_LANE) begin : g_lane
      assign lane_ext[k] = `XB_LANE(bus.in_data, k, DW_DATA);
    end else begin : g_zero
      assign lane_ext[k] = '0;
    end
  end

  for (genvar j = 0; j < N_LANE; j++) begin : g_out
    assign routed[j] = mask_q[j] ? '0 : (bcast_q ? lane_ext[0] : lane_ext[sel_q[j]]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) beat_cnt <= '0;
    else if (in_fire) begin
      if (bus.in_last)          beat_cnt <= '0;
      else if (beat_cnt != '1)  beat_cnt <= beat_cnt + 1'b1;
    end
  end

  crossbar_skid_buf #(.W(DW_BUS + 1)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (bus.in_valid && (state == RUN)),
    .in_ready  (sk_ready),
    .in_data   ({bus.in_last, routed}),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (sk_out)
  );

  assign bus.out_data = sk_out[DW_BUS-1:0];
  assign bus.out_last = sk_out[DW_BUS];
endmodule
